// File: rtl/i2c_slv_fsm.sv
// I2C target FSM: START/STOP detect, 7-bit address match, register pointer, burst write and burst read with auto-increment.
// Latency: 2-flop sync + 1 history flop (+FILT_LEN with the glitch filter) from pin to edge; SDA drive updates 1 CLK after a seen SCL fall.
// Backpressure: none; SCL is never stretched and the register bank must take every WE/RE strobe. Optional filter macro: I2C_SLV_GLITCH_FILT_EN.
module i2c_slv_fsm #(
    parameter int                 ADDR_SZ  = 7,
    parameter int                 DATA_SZ  = 8,
    parameter int                 REG_AW   = 8,
    parameter logic [ADDR_SZ-1:0] SLV_ADDR = 7'h68,
    parameter int                 FILT_LEN = 4
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               I_SCL,
    input  logic               I_SDA,
    output logic               O_SDA_OE,
    output logic [REG_AW-1:0]  O_REG_ADDR,
    output logic [DATA_SZ-1:0] O_REG_WDATA,
    output logic               O_REG_WE,
    output logic               O_REG_RE,
    input  logic [DATA_SZ-1:0] I_REG_RDATA,
    output logic               O_BUSY,
    output logic               O_ADDR_HIT
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WR, ACK_WR, RD, MACK, IGNORE
    } state_t;

    // Bit counter: counts remaining bits down to 0; RD_FRESH marks a read byte with no bit driven yet.
    localparam logic [3:0] BIT_MSB  = 4'(DATA_SZ - 1);
    localparam logic [3:0] RD_FRESH = 4'(DATA_SZ);

    logic scl_cur, scl_prv, sda_cur, sda_prv;

`ifdef I2C_SLV_GLITCH_FILT_EN
    localparam int FCW = $clog2(FILT_LEN + 1);

    logic [1:0]     scl_sync_q, sda_sync_q;
    logic           scl_f_q, sda_f_q, scl_h_q, sda_h_q;
    logic [FCW-1:0] scl_fc_q, sda_fc_q;

    // Synchronize, then accept a new level only after FILT_LEN consecutive differing samples.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
            scl_h_q    <= 1'b1;
            sda_h_q    <= 1'b1;
            scl_fc_q   <= '0;
            sda_fc_q   <= '0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], I_SCL};
            sda_sync_q <= {sda_sync_q[0], I_SDA};
            scl_h_q    <= scl_f_q;
            sda_h_q    <= sda_f_q;
            if (scl_sync_q[1] == scl_f_q) begin
                scl_fc_q <= '0;
            end else if (scl_fc_q == FCW'(FILT_LEN - 1)) begin
                scl_f_q  <= scl_sync_q[1];
                scl_fc_q <= '0;
            end else begin
                scl_fc_q <= scl_fc_q + 1'b1;
            end
            if (sda_sync_q[1] == sda_f_q) begin
                sda_fc_q <= '0;
            end else if (sda_fc_q == FCW'(FILT_LEN - 1)) begin
                sda_f_q  <= sda_sync_q[1];
                sda_fc_q <= '0;
            end else begin
                sda_fc_q <= sda_fc_q + 1'b1;
            end
        end
    end

    assign scl_cur = scl_f_q;
    assign scl_prv = scl_h_q;
    assign sda_cur = sda_f_q;
    assign sda_prv = sda_h_q;
`else
    logic [2:0] scl_sync_q, sda_sync_q;

    // Two synchronizer flops plus one history flop per line; idle bus level is high.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], I_SCL};
            sda_sync_q <= {sda_sync_q[1:0], I_SDA};
        end
    end

    assign scl_cur = scl_sync_q[1];
    assign scl_prv = scl_sync_q[2];
    assign sda_cur = sda_sync_q[1];
    assign sda_prv = sda_sync_q[2];
`endif

    // SCL must be high in both samples, so an SDA change on an SCL edge is data, not START/STOP.
    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  =  scl_cur & ~scl_prv;
    assign scl_fall  = ~scl_cur &  scl_prv;
    assign start_det =  scl_cur &  scl_prv &  sda_prv & ~sda_cur;
    assign stop_det  =  scl_cur &  scl_prv & ~sda_prv &  sda_cur;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [DATA_SZ-1:0] rx_q, rx_d, tx_q, tx_d, wdata_q, wdata_d, rx_shift;
    logic [REG_AW-1:0]  ptr_q, ptr_d;
    logic               oe_q, oe_d, ack_q, ack_d, busy_q, busy_d;
    logic               hit_q, hit_d, we_q, we_d, re_q, re_d, cap_q, cap_d;

    assign rx_shift = {rx_q[DATA_SZ-2:0], sda_cur};

    // Next-state and datapath: START/STOP override everything, otherwise per-state bit handling.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        ptr_d   = ptr_q;
        wdata_d = wdata_q;
        oe_d    = oe_q;
        ack_d   = ack_q;
        busy_d  = busy_q;
        hit_d   = 1'b0;
        we_d    = 1'b0;
        re_d    = 1'b0;
        cap_d   = re_q;
        // Read data lands one CLK after RE; pointer steps after a capture or a write strobe.
        if (cap_q) begin
            tx_d  = I_REG_RDATA;
            ptr_d = ptr_q + 1'b1;
        end
        if (we_q) begin
            ptr_d = ptr_q + 1'b1;
        end
        if (start_det) begin
            state_d = ADDR;
            cnt_d   = BIT_MSB;
            oe_d    = 1'b0;
            ack_d   = 1'b0;
            busy_d  = 1'b0;
        end else if (stop_det) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            ack_d   = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WR: if (scl_rise) begin
                    rx_d = rx_shift;
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (state_q == PTR) begin
                        ptr_d   = REG_AW'(rx_shift);
                        state_d = ACK_PTR;
                    end else if (state_q == WR) begin
                        we_d    = 1'b1;
                        wdata_d = rx_shift;
                        state_d = ACK_WR;
                    end else if (rx_shift[DATA_SZ-1 -: ADDR_SZ] == SLV_ADDR) begin
                        hit_d   = 1'b1;
                        busy_d  = 1'b1;
                        re_d    = rx_shift[0];
                        state_d = ACK_ADDR;
                    end else begin
                        state_d = IGNORE;
                    end
                end
                ACK_ADDR, ACK_PTR, ACK_WR: if (scl_fall) begin
                    if (!ack_q) begin
                        oe_d  = 1'b1;
                        ack_d = 1'b1;
                    end else begin
                        ack_d = 1'b0;
                        cnt_d = BIT_MSB;
                        oe_d  = 1'b0;
                        if (state_q == ACK_ADDR && rx_q[0]) begin
                            oe_d    = ~tx_q[DATA_SZ-1];
                            state_d = RD;
                        end else if (state_q == ACK_ADDR) begin
                            state_d = PTR;
                        end else begin
                            state_d = WR;
                        end
                    end
                end
                RD: if (scl_fall) begin
                    if (cnt_q == 4'd0) begin
                        oe_d    = 1'b0;
                        state_d = MACK;
                    end else if (cnt_q == RD_FRESH) begin
                        oe_d  = ~tx_q[DATA_SZ-1];
                        cnt_d = BIT_MSB;
                    end else begin
                        oe_d  = ~tx_q[DATA_SZ-2];
                        tx_d  = {tx_q[DATA_SZ-2:0], 1'b0};
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                MACK: if (scl_rise) begin
                    if (!sda_cur) begin
                        re_d    = 1'b1;
                        cnt_d   = RD_FRESH;
                        state_d = RD;
                    end else begin
                        busy_d  = 1'b0;
                        oe_d    = 1'b0;
                        state_d = IGNORE;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and datapath registers; reset releases SDA at once.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            ptr_q   <= '0;
            wdata_q <= '0;
            oe_q    <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            hit_q   <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            cap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            ptr_q   <= ptr_d;
            wdata_q <= wdata_d;
            oe_q    <= oe_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            hit_q   <= hit_d;
            we_q    <= we_d;
            re_q    <= re_d;
            cap_q   <= cap_d;
        end
    end

    assign O_SDA_OE    = oe_q;
    assign O_REG_ADDR  = ptr_q;
    assign O_REG_WDATA = wdata_q;
    assign O_REG_WE    = we_q;
    assign O_REG_RE    = re_q;
    assign O_BUSY      = busy_q;
    assign O_ADDR_HIT  = hit_q;

endmodule

// File: tb/tb_i2c_slv_fsm.sv
// Bench for i2c_slv_fsm: bit-banged I2C master, wired-AND SDA, small register bank and strobe monitors.
// Latency: bus quarter-bit is Q CLKs, far longer than the DUT's edge detection latency.
// Backpressure: none; the bank answers every RE on the following CLK.
module tb_i2c_slv_fsm;

    localparam int Q = 10;

    logic       CLK = 1'b0;
    logic       RST_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       oe, we, re, busy, hit;
    logic [7:0] reg_addr, wdata, rdata;

    assign sda_line = sda_m & ~oe;

    i2c_slv_fsm dut (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .I_SCL       (scl_m),
        .I_SDA       (sda_line),
        .O_SDA_OE    (oe),
        .O_REG_ADDR  (reg_addr),
        .O_REG_WDATA (wdata),
        .O_REG_WE    (we),
        .O_REG_RE    (re),
        .I_REG_RDATA (rdata),
        .O_BUSY      (busy),
        .O_ADDR_HIT  (hit)
    );

    always #10 CLK = ~CLK;

    // Register bank contents: address maps to a fixed pattern, with the MPU-6050 values the tests read.
    function automatic logic [7:0] bank_val(input logic [7:0] a);
        if (a == 8'h75) return 8'h68;
        if (a == 8'h76) return 8'h11;
        return 8'hEE;
    endfunction

    always @(posedge CLK) begin
        if (re) rdata <= bank_val(reg_addr);
    end

    int         n_chk = 0, n_fail = 0;
    int         we_cnt = 0, re_cnt = 0, hit_cnt = 0, oe_cnt = 0;
    logic [7:0] we_a_log[$], we_d_log[$], re_a_log[$];

    // Strobe monitor sampled on the inactive edge.
    always @(negedge CLK) begin
        if (we) begin
            we_cnt++;
            we_a_log.push_back(reg_addr);
            we_d_log.push_back(wdata);
        end
        if (re) begin
            re_cnt++;
            re_a_log.push_back(reg_addr);
        end
        if (hit) hit_cnt++;
        if (oe)  oe_cnt++;
    end

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Works from idle and as a repeated start (SCL low on entry).
    task automatic i2c_start();
        sda_m = 1'b1; clk_wait(Q);
        scl_m = 1'b1; clk_wait(Q);
        sda_m = 1'b0; clk_wait(Q);
        scl_m = 1'b0; clk_wait(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; clk_wait(Q);
        scl_m = 1'b1; clk_wait(Q);
        sda_m = 1'b1; clk_wait(Q);
    endtask

    task automatic xfer_bit(input logic b, output logic r);
        sda_m = b;    clk_wait(Q);
        scl_m = 1'b1; clk_wait(Q);
        r = sda_line; clk_wait(Q);
        scl_m = 1'b0; clk_wait(Q);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) xfer_bit(d[i], r);
        xfer_bit(1'b1, ack);
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b1, r);
            d[i] = r;
        end
        xfer_bit(mack, r);
    endtask

    typedef struct {
        logic [7:0] ptr;
        logic [7:0] data;
        logic [7:0] exp_addr;
        logic [7:0] exp_wdata;
        logic [7:0] exp_ptr_end;
    } wvec_t;

    wvec_t vec[4];

`ifdef I2C_SLV_GLITCH_FILT_EN
    localparam logic [7:0] GLITCH_BYTE = 8'hA5;
    localparam logic       GLITCH_ACK  = 1'b0;
`else
    localparam logic [7:0] GLITCH_BYTE = 8'hD2;
    localparam logic       GLITCH_ACK  = 1'b1;
`endif

    initial begin
        logic       ack, r;
        logic [7:0] d;
        logic [7:0] gbyte;
        int         w0, r0, h0, o0, wl, rl;

        vec[0] = '{8'h6B, 8'h00, 8'h6B, 8'h00, 8'h6C};
        vec[1] = '{8'h10, 8'hA5, 8'h10, 8'hA5, 8'h11};
        vec[2] = '{8'h7F, 8'h3C, 8'h7F, 8'h3C, 8'h80};
        vec[3] = '{8'hFF, 8'h5A, 8'hFF, 8'h5A, 8'h00};
        gbyte  = 8'hA5;

        // Reset values
        clk_wait(5);
        chk1("rst_oe", oe, 1'b0);
        chk8("rst_addr", reg_addr, 8'h00);
        chk8("rst_wdata", wdata, 8'h00);
        chk1("rst_we", we, 1'b0);
        chk1("rst_re", re, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_hit", hit, 1'b0);
        RST_n = 1'b1;
        clk_wait(5);

        // Single-byte writes from the table
        for (int v = 0; v < 4; v++) begin
            w0 = we_cnt; h0 = hit_cnt; wl = we_a_log.size();
            i2c_start();
            wr_byte(8'hD0, ack);
            chk1("wr_ack_addr", ack, 1'b0);
            chk1("wr_busy", busy, 1'b1);
            chkn("wr_hit_cnt", hit_cnt - h0, 1);
            wr_byte(vec[v].ptr, ack);
            chk1("wr_ack_ptr", ack, 1'b0);
            wr_byte(vec[v].data, ack);
            chk1("wr_ack_data", ack, 1'b0);
            i2c_stop();
            clk_wait(4);
            chkn("wr_we_cnt", we_cnt - w0, 1);
            if (we_a_log.size() > wl) begin
                chk8("wr_we_addr", we_a_log[wl], vec[v].exp_addr);
                chk8("wr_we_data", we_d_log[wl], vec[v].exp_wdata);
            end
            chk8("wr_ptr_end", reg_addr, vec[v].exp_ptr_end);
            chk1("wr_busy_after_stop", busy, 1'b0);
        end

        // Pointer write, repeated START, two-byte read (ACK then NACK)
        w0 = we_cnt; r0 = re_cnt; rl = re_a_log.size();
        i2c_start();
        wr_byte(8'hD0, ack); chk1("rd_ack_addr_w", ack, 1'b0);
        wr_byte(8'h75, ack); chk1("rd_ack_ptr", ack, 1'b0);
        i2c_start();
        wr_byte(8'hD1, ack); chk1("rd_ack_addr_r", ack, 1'b0);
        rd_byte(1'b0, d);    chk8("rd_byte0", d, 8'h68);
        rd_byte(1'b1, d);    chk8("rd_byte1", d, 8'h11);
        chk1("rd_oe_after_nack", oe, 1'b0);
        chk1("rd_busy_after_nack", busy, 1'b0);
        i2c_stop();
        clk_wait(4);
        chkn("rd_re_cnt", re_cnt - r0, 2);
        chkn("rd_we_cnt", we_cnt - w0, 0);
        if (re_a_log.size() >= rl + 2) begin
            chk8("rd_re_addr0", re_a_log[rl], 8'h75);
            chk8("rd_re_addr1", re_a_log[rl+1], 8'h76);
        end
        chk8("rd_ptr_end", reg_addr, 8'h77);

        // Foreign address is ignored, then own address is acknowledged
        w0 = we_cnt; r0 = re_cnt; h0 = hit_cnt; o0 = oe_cnt;
        i2c_start();
        wr_byte(8'hA0, ack); chk1("nm_nack", ack, 1'b1);
        wr_byte(8'h55, ack); chk1("nm_nack_data", ack, 1'b1);
        i2c_stop();
        chkn("nm_oe_cnt", oe_cnt - o0, 0);
        chkn("nm_hit_cnt", hit_cnt - h0, 0);
        chkn("nm_we_cnt", we_cnt - w0, 0);
        chkn("nm_re_cnt", re_cnt - r0, 0);
        chk1("nm_busy", busy, 1'b0);
        i2c_start();
        wr_byte(8'hD0, ack); chk1("nm_next_ack", ack, 1'b0);
        chkn("nm_next_hit", hit_cnt - h0, 1);
        i2c_stop();

        // Burst write across the pointer wrap
        wl = we_a_log.size();
        i2c_start();
        wr_byte(8'hD0, ack);
        wr_byte(8'hFF, ack);
        wr_byte(8'h12, ack); chk1("wrap_ack0", ack, 1'b0);
        wr_byte(8'h34, ack); chk1("wrap_ack1", ack, 1'b0);
        i2c_stop();
        clk_wait(4);
        chkn("wrap_we_cnt", we_a_log.size() - wl, 2);
        if (we_a_log.size() >= wl + 2) begin
            chk8("wrap_addr0", we_a_log[wl], 8'hFF);
            chk8("wrap_data0", we_d_log[wl], 8'h12);
            chk8("wrap_addr1", we_a_log[wl+1], 8'h00);
            chk8("wrap_data1", we_d_log[wl+1], 8'h34);
        end
        chk8("wrap_ptr_end", reg_addr, 8'h01);

        // Reset while driving a 0 read bit
        i2c_start();
        wr_byte(8'hD0, ack);
        wr_byte(8'h75, ack);
        i2c_start();
        wr_byte(8'hD1, ack);
        chk1("rst_mid_oe_before", oe, 1'b1);
        #3 RST_n = 1'b0;
        #1;
        chk1("rst_mid_oe", oe, 1'b0);
        chk1("rst_mid_busy", busy, 1'b0);
        scl_m = 1'b1; sda_m = 1'b1;
        clk_wait(4);
        RST_n = 1'b1;
        clk_wait(4);
        chk8("rst_mid_ptr", reg_addr, 8'h00);
        h0 = hit_cnt; o0 = oe_cnt;
        wr_byte(8'hD0, ack);
        chk1("rst_idle_nack", ack, 1'b1);
        chkn("rst_idle_hit", hit_cnt - h0, 0);
        chkn("rst_idle_oe", oe_cnt - o0, 0);
        i2c_stop();

        // Short low glitch on SCL during the first data bit of a write
        w0 = we_cnt; wl = we_a_log.size();
        i2c_start();
        wr_byte(8'hD0, ack);
        wr_byte(8'h20, ack);
        sda_m = gbyte[7]; clk_wait(Q);
        scl_m = 1'b1; clk_wait(3);
        scl_m = 1'b0; clk_wait(2);
        scl_m = 1'b1; clk_wait(2*Q - 5);
        scl_m = 1'b0; clk_wait(Q);
        for (int i = 6; i >= 0; i--) xfer_bit(gbyte[i], r);
        xfer_bit(1'b1, ack);
        chk1("glitch_ack", ack, GLITCH_ACK);
        i2c_stop();
        clk_wait(4);
        chkn("glitch_we_cnt", we_cnt - w0, 1);
        if (we_a_log.size() > wl) begin
            chk8("glitch_we_addr", we_a_log[wl], 8'h20);
            chk8("glitch_we_data", we_d_log[wl], GLITCH_BYTE);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_slv_fsm.md
Name: i2c_slv_fsm

Overview:
I2C target (slave) for the same 50 MHz fabric as the existing I2C master FSM. It lets our master, and the bench, talk to an on-chip register model of the MPU-6050 register map. The block oversamples SCL/SDA with CLK, detects START/STOP, matches a 7-bit address and handles the register-pointer protocol (pointer write, burst write, burst read with auto-increment). It drives a simple synchronous register-bank port and drives SDA open-drain only.

Parameters:
ADDR_SZ, 7, target address width
DATA_SZ, 8, data byte width
REG_AW, 8, register pointer width
SLV_ADDR, 7'h68, own target address
FILT_LEN, 4, glitch-filter stability length in CLK cycles (used only with the optional feature)

Ports:
CLK  in  1  clock 50 MHz
RST_n  in  1  asynchronous reset, active-low
I_SCL  in  1  serial clock from bus (asynchronous)
I_SDA  in  1  serial data from bus (asynchronous)
O_SDA_OE  out  1  1 = pull SDA low; 0 = release
O_REG_ADDR  out  REG_AW  current register pointer
O_REG_WDATA  out  DATA_SZ  byte to write
O_REG_WE  out  1  one-CLK write strobe
O_REG_RE  out  1  one-CLK read strobe
I_REG_RDATA  in  DATA_SZ  read data, valid 1 CLK after O_REG_RE
O_BUSY  out  1  high from address match until STOP/START/NACK release
O_ADDR_HIT  out  1  one-CLK pulse on own-address match

Behaviour:
- Reset values (async, RST_n low): all outputs 0; state IDLE; pointer 0; SDA released. Reset mid-transfer releases SDA immediately.
- Inputs pass through a 2-flop synchronizer; a third flop gives the edge history.
- Edge definitions: scl_rise/scl_fall are edges of the synchronized SCL.
- START: synchronized SDA falls while synchronized SCL is high in both the current and previous sample. STOP: same condition, SDA rising.
- An SDA change coincident with an SCL edge is treated as data, not START/STOP.
- Sampling and driving: bits are sampled on scl_rise. O_SDA_OE changes only on the CLK after scl_fall.
- States: IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WR, ACK_WR, RD, MACK, IGNORE.
- START from any state -> ADDR (this is also the repeated-start case), bit counter = 7, SDA released.
- STOP from any state -> IDLE, SDA released, O_BUSY = 0.
- ADDR: shift 8 bits MSB first.
  - On match of bits[7:1] with SLV_ADDR: pulse O_ADDR_HIT, set O_BUSY, go to ACK_ADDR.
  - On mismatch: go to IGNORE and keep SDA released until the next START/STOP.
- ACK_ADDR: drive OE=1 from the scl_fall after the 8th bit until the next scl_fall.
  - R/W=0: then go to PTR.
  - R/W=1: pulse O_REG_RE on entry to ACK_ADDR, capture I_REG_RDATA the next CLK into the TX shifter, increment the pointer, go to RD.
- PTR: shift 8 bits, load them into the pointer, ACK as above (ACK_PTR), then go to WR.
- WR: shift 8 bits. One CLK after the 8th scl_rise:
  - O_REG_WDATA = byte, O_REG_WE = 1 for one CLK, O_REG_ADDR = pointer.
  - The pointer increments on the following CLK.
  - ACK (ACK_WR), then return to WR.
- RD:
  - On each scl_fall, OE = ~tx_bit, MSB first. The first bit is driven at the scl_fall that ends the ACK.
  - After the 8th bit's scl_fall, release SDA and go to MACK.
- MACK: sample SDA on scl_rise.
  - 0 (ACK): pulse O_REG_RE, load the next byte, increment the pointer, go to RD.
  - 1 (NACK): go to IGNORE, SDA released, O_BUSY = 0.
- Pointer wraps modulo 2^REG_AW (0xFF + 1 = 0x00).
- The block never stretches SCL.

Optional Feature:
Macro I2C_SLV_GLITCH_FILT_EN.
- Defined: after the synchronizer, each of SCL/SDA is updated only when its raw synchronized value has been stable for FILT_LEN consecutive CLKs. Pulses shorter than FILT_LEN CLKs are ignored. Edge detection latency grows by FILT_LEN cycles.
- Undefined: 2-flop synchronizer only; no filtering.

Test Plan:
1. Write START, 0xD0, ptr 0x6B, data 0x00, STOP -> ACK on all 3 bytes; one WE with O_REG_ADDR=0x6B, WDATA=0x00; pointer ends 0x6C; O_BUSY 0 after STOP.
2. Read START, 0xD0, ptr 0x75, repeated START, 0xD1, master ACK then NACK, STOP (bank returns 0x68 at 0x75, 0x11 at 0x76) -> two RE pulses; bus bytes 0x68 then 0x11; SDA released after the NACK.
3. Address 0xA0 -> no ACK, OE never 1, no WE/RE, O_ADDR_HIT never pulses; the next transaction with 0xD0 is acknowledged normally.
4. Pointer 0xFF, burst write 0x12, 0x34 -> WE at address 0xFF then 0x00.
5. RST_n asserted while OE=1 in the middle of an RD bit -> OE=0 immediately; after release, state IDLE and pointer 0.
6. With the macro defined: a 2-CLK low glitch on SCL during WR -> bit count unchanged, no extra sample. Without the macro: the bench observes one extra sampled bit.
